// File: rtl/bsg_cgol_pkg.sv
// Shared types and helpers for the Game of Life grid controller.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } cgol_state_e;

  // Width of the generation counter; never narrower than one bit.
  function automatic int frame_width(input int max_len);
    int w;
    w = $clog2(max_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bsg_cgol_ctrl_if.sv
// Board/generation-count input handshake and result output handshake.
interface bsg_cgol_ctrl_if #(
  parameter int n_p  = 64,
  parameter int fw_p = 10
);
  logic            v_i;
  logic [n_p-1:0]  data_i;
  logic [fw_p-1:0] frames_i;
  logic            ready_o;
  logic            v_o;
  logic [n_p-1:0]  data_o;
  logic            yumi_i;

  modport slave (
    input  v_i, data_i, frames_i, yumi_i,
    output ready_o, v_o, data_o
  );

  modport master (
    output v_i, data_i, frames_i, yumi_i,
    input  ready_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_cgol_frame_counter.sv
// Down-counter of remaining generations; saturates at zero instead of wrapping.
module bsg_cgol_frame_counter #(
  parameter int width_p = 10
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o,
  output logic               one_o
);
  localparam logic [width_p-1:0] one_lp = width_p'(1);

  logic [width_p-1:0] count_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (load_i) begin
      count_r <= load_val_i;
    end else if (dec_i && (count_r != '0)) begin
      count_r <= count_r - one_lp;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero_o = (count_r == '0);
  assign one_o  = (count_r == one_lp);

endmodule

// File: rtl/bsg_cgol_ctrl.sv
// Control FSM for a Game of Life cell grid: accepts a board and a generation
// count, loads the grid, steps it that many times, then presents the result.
module bsg_cgol_ctrl
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p  = 8,
  parameter int max_game_len_p = 1000
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  bsg_cgol_ctrl_if.slave                         io,
  output logic                                   update_o,
  output logic [board_width_p*board_width_p-1:0] update_val_o,
  output logic                                   en_o,
  input  logic [board_width_p*board_width_p-1:0] grid_data_i
);
  localparam int n_lp  = board_width_p * board_width_p;
  localparam int fw_lp = frame_width(max_game_len_p);

  cgol_state_e     state_r;
  cgol_state_e     state_next_s;
  logic [n_lp-1:0] load_r;
  logic            accept_s;
  logic            busy_s;
  logic            cnt_zero_s;
  logic            cnt_one_s;

  assign accept_s = (state_r == ST_IDLE) && io.v_i;
  assign busy_s   = (state_r == ST_BUSY);

  bsg_cgol_frame_counter #(
    .width_p(fw_lp)
  ) u_frame_counter (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (accept_s),
    .load_val_i (io.frames_i),
    .dec_i      (busy_s),
    .zero_o     (cnt_zero_s),
    .one_o      (cnt_one_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Captured board, only written on an accepted transfer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      load_r <= '0;
    end else if (accept_s) begin
      load_r <= io.data_i;
    end else begin
      load_r <= load_r;
    end
  end

  // Next-state logic; the zero test in BUSY is a guard that cannot normally fire.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (io.v_i) state_next_s = ST_LOAD;
        else        state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (cnt_zero_s) state_next_s = ST_DONE;
        else            state_next_s = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt_one_s || cnt_zero_s) state_next_s = ST_DONE;
        else                         state_next_s = ST_BUSY;
      end
      ST_DONE: begin
        if (io.yumi_i) state_next_s = ST_IDLE;
        else           state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Moore output decode straight from the state register.
  always_comb begin
    io.ready_o   = 1'b0;
    io.v_o       = 1'b0;
    io.data_o    = '0;
    update_o     = 1'b0;
    update_val_o = '0;
    en_o         = 1'b0;
    case (state_r)
      ST_IDLE: io.ready_o = 1'b1;
      ST_LOAD: begin
        update_o     = 1'b1;
        update_val_o = load_r;
      end
      ST_BUSY: en_o = 1'b1;
      ST_DONE: begin
        io.v_o    = 1'b1;
        io.data_o = grid_data_i;
      end
      default: io.ready_o = 1'b0;
    endcase
  end

endmodule

// File: doc/bsg_cgol_ctrl.md
BSG_CGOL_CTRL -- requirements
Module: bsg_cgol_ctrl

Interface
REQ-001 SHALL have parameter board_width_p, default 8, meaning the board is board_width_p x board_width_p cells (N = board_width_p*board_width_p).
REQ-002 SHALL have parameter max_game_len_p, default 1000, meaning the largest legal generation count; FW = $clog2(max_game_len_p+1).
REQ-003 SHALL have port clk_i input 1: the single clock; one clock domain, all state on posedge clk_i.
REQ-004 SHALL have port reset_n_i input 1: asynchronous, active-low reset.
REQ-005 SHALL have ports v_i input 1, data_i input N, frames_i input FW, ready_o output 1: the initial-board and generation-count handshake.
REQ-006 SHALL have ports update_o output 1 and update_val_o output N: the load strobe and per-cell load values to the cell grid.
REQ-007 SHALL have port en_o output 1: the grid-wide step enable; each cycle high advances one generation.
REQ-008 SHALL have port grid_data_i input N: the current per-cell status from the grid; bit index r*board_width_p+c.
REQ-009 SHALL have ports v_o output 1, data_o output N, yumi_i input 1: the result handshake; yumi_i is legal only when v_o=1.

Function
REQ-010 SHALL implement a four-state FSM: IDLE, LOAD, BUSY, DONE.
REQ-011 In IDLE, ready_o SHALL be 1 and all other outputs SHALL be 0; v_i=1 completes a transfer, captures data_i into the load register and frames_i into the frame counter, and moves to LOAD.
REQ-012 In LOAD, update_o SHALL be 1 for exactly one cycle with update_val_o equal to the captured board; en_o SHALL be 0.
REQ-013 From LOAD, the FSM SHALL go to DONE if the captured count is 0, else to BUSY.
REQ-014 In BUSY, en_o SHALL be 1 each cycle; the counter decrements by 1 per cycle; on the cycle the counter reads 1 the FSM SHALL move to DONE, giving exactly frames_i en_o cycles.
REQ-015 In DONE, v_o SHALL be 1 and data_o SHALL equal grid_data_i; en_o and update_o SHALL be 0 so the board holds.
REQ-016 In DONE, yumi_i=1 SHALL return the FSM to IDLE next cycle; yumi_i=0 holds DONE indefinitely with data_o stable.
REQ-017 update_o and en_o SHALL never be 1 in the same cycle.
REQ-018 ready_o SHALL be 0 outside IDLE; v_i outside IDLE SHALL be ignored and not captured.
REQ-019 frames_i values greater than max_game_len_p are illegal; behaviour for them is undefined.
REQ-020 Input-to-first-en_o latency SHALL be 2 cycles (IDLE accept, LOAD, BUSY); accept-to-v_o latency SHALL be frames_i+2 cycles.
REQ-021 update_val_o SHALL be 0 whenever update_o is 0.

Reset
REQ-022 reset_n_i low SHALL asynchronously force state IDLE, counter 0, load register 0, and ready_o=1, v_o=0, update_o=0, en_o=0, data_o=0.
REQ-023 Reset asserted in any state, including mid-BUSY or mid-DONE, SHALL abort the game with no further en_o or update_o; the grid contents are not cleared.
REQ-024 The first accept after reset deassertion SHALL be possible on the first rising edge with reset_n_i high.

Structure
REQ-025 The FSM state enum and the FW width function SHALL live in shared package bsg_cgol_pkg.
REQ-026 The frame counter SHALL be sub-module bsg_cgol_frame_counter (load, decrement, is-zero, is-one outputs, async active-low reset).
REQ-027 The block SHALL contain no cell logic; it drives a grid of cell instances through update_o, update_val_o and en_o only.

Verification
REQ-028 Blinker: 8x8, vertical triple at (3,2),(3,3),(3,4), frames_i=1 -> one en_o pulse; data_o shows horizontal triple at (2,3),(3,3),(4,3); v_o at accept+3.
REQ-029 Zero frames: frames_i=0, any board -> update_o one cycle, no en_o, v_o=1 with data_o==data_i at accept+2.
REQ-030 Backpressure: glider, frames_i=4, yumi_i held 0 for 10 cycles -> v_o stays 1, data_o is the glider shifted (+1,+1), en_o stays 0, ready_o stays 0.
REQ-031 Reset mid-BUSY: frames_i=100, reset_n_i low after 20 en_o cycles -> all outputs at reset values immediately, ready_o=1; next transfer runs normally.
REQ-032 Ignored input: v_i=1 held throughout BUSY with different data -> no second capture; exactly frames_i en_o pulses; ready_o=0 until IDLE.
REQ-033 Max length: frames_i=max_game_len_p -> exactly max_game_len_p en_o cycles, counter reaches 0 with no wrap.
